// File: rtl/axi4s_byte_downsizer.sv
// axi4s_byte_downsizer: serialises multi-byte AXI4-Stream words into one byte per beat, dropping null lanes
module axi4s_byte_downsizer #(
    parameter int IN_BYTES = 4,
    parameter int CNTW     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IN_BYTES*8-1:0] s_tdata,
    input  logic [IN_BYTES-1:0]   s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [7:0]            m_tdata,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [CNTW-1:0]       pkt_cnt,
    output logic                  err_null_last
);
    logic [IN_BYTES*8-1:0] buf_data_q, buf_data_d;
    logic [IN_BYTES-1:0]   rem_q, rem_d, rem_clr;
    logic                  buf_last_q, buf_last_d, err_q, err_d;
    logic                  single, in_hs, out_hs;
    logic [CNTW-1:0]       pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        rem_clr  = rem_q & (rem_q - IN_BYTES'(1));
        single   = (rem_q != '0) && (rem_clr == '0);
        m_tvalid = |rem_q;
        m_tlast  = buf_last_q & single;
        s_tready = (rem_q == '0) | (m_tready & single);
        m_tdata  = '0;
        // Descending scan so the lowest pending lane wins.
        for (int i = IN_BYTES - 1; i >= 0; i--)
            if (rem_q[i]) m_tdata = buf_data_q[8*i +: 8];
        out_hs     = m_tvalid & m_tready;
        in_hs      = s_tvalid & s_tready;
        rem_d      = in_hs ? s_tkeep : out_hs ? rem_clr : rem_q;
        buf_data_d = in_hs ? s_tdata : buf_data_q;
        buf_last_d = in_hs ? s_tlast : buf_last_q;
        pkt_cnt_d  = pkt_cnt_q + CNTW'(out_hs & m_tlast);
        err_d      = err_q | (in_hs & s_tlast & (s_tkeep == '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q      <= '0;
            buf_last_q <= 1'b0;
            pkt_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            buf_last_q <= buf_last_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) buf_data_q <= buf_data_d;

    assign pkt_cnt       = pkt_cnt_q;
    assign err_null_last = err_q;
endmodule

// File: tb/tb_axi4s_byte_downsizer.sv
// tb_axi4s_byte_downsizer: scenario tasks plus a random soak against a lane-order reference model
module tb_axi4s_byte_downsizer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast, s_tvalid, s_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast, m_tvalid, m_tready;
    logic [3:0]  pkt_cnt;
    logic        err_null_last;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int cyc = 0;
    logic [9:0] got_q[$];
    int         got_t[$];
    logic [8:0] exp_q[$];

    axi4s_byte_downsizer #(.IN_BYTES(4), .CNTW(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .pkt_cnt(pkt_cnt), .err_null_last(err_null_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // Each beat is recorded as {s_tready, m_tlast, m_tdata} seen half a cycle before its handshake edge.
    always @(negedge clk)
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            got_q.push_back({s_tready, m_tlast, m_tdata});
            got_t.push_back(cyc);
        end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t = 0;
        bit hs = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        while (!hs && t < 1000) begin
            @(negedge clk);
            hs = (s_tready === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        s_tvalid = 1'b0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL send_word_timeout word=%h keep=%b got no s_tready, need handshake", d, k);
        end
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (got_q.size() < n && t < 500) begin
            tick(1);
            t++;
        end
        if (got_q.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_beats got=%0d beats need=%0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b1;
        #12;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got=%b need=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast got=%b need=0", m_tlast); end
        checks++; if (pkt_cnt !== 4'd0) begin errors++; $display("FAIL reset_pkt_cnt got=%0d need=0", pkt_cnt); end
        checks++; if (err_null_last !== 1'b0) begin errors++; $display("FAIL reset_err got=%b need=0", err_null_last); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_cnt = 0;
        #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready got=%b need=1", s_tready); end
        tick(1);
    endtask

    task automatic test_full_words;
        logic [7:0] eb[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        got_q.delete(); got_t.delete();
        m_tready = 1'b1;
        send_word(32'h44332211, 4'hF, 1'b0);
        send_word(32'h88776655, 4'hF, 1'b1);
        wait_beats(8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {(i == 3 || i == 7), (i == 7), eb[i]} || got_t[i] !== got_t[0] + i) begin
                errors++;
                $display("FAIL full_beat%0d got rdy/last/data=%h at cyc %0d, need %h at cyc %0d",
                         i, got_q[i], got_t[i], {(i == 3 || i == 7), (i == 7), eb[i]}, got_t[0] + i);
            end
        end
        tick(2);
        exp_cnt++;
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL full_count got=%0d need=8", got_q.size()); end
        checks++; if (pkt_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL full_pkt_cnt got=%0d need=%0d", pkt_cnt, 4'(exp_cnt)); end
    endtask

    task automatic test_sparse_null;
        logic [8:0] eb[3] = '{9'h0BB, 9'h0DD, 9'h1EE};
        got_q.delete(); got_t.delete();
        send_word(32'hDDCCBBAA, 4'b1010, 1'b0);
        send_word($urandom, 4'h0, 1'b0);
        send_word(32'h000000EE, 4'b0001, 1'b1);
        wait_beats(3);
        tick(2);
        exp_cnt++;
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL sparse_count got=%0d need=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][8:0] !== eb[i]) begin
                errors++; $display("FAIL sparse_beat%0d got=%h need=%h", i, got_q[i][8:0], eb[i]);
            end
        end
        checks++; if (err_null_last !== 1'b0) begin errors++; $display("FAIL sparse_err got=%b need=0", err_null_last); end
        checks++; if (pkt_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL sparse_pkt_cnt got=%0d need=%0d", pkt_cnt, 4'(exp_cnt)); end
    endtask

    task automatic test_backpressure;
        logic [6:0] pat = 7'b1101001;
        logic [7:0] eb[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int idx = 0;
        got_q.delete(); got_t.delete();
        send_word(32'h04030201, 4'hF, 1'b0);
        for (int i = 0; i < 7; i++) begin
            m_tready = pat[i];
            @(negedge clk);
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== eb[idx] || s_tready !== (i == 6)) begin
                errors++;
                $display("FAIL bp_cycle%0d got valid=%b data=%h s_tready=%b, need valid=1 data=%h s_tready=%b",
                         i, m_tvalid, m_tdata, s_tready, eb[idx], (i == 6));
            end
            if (pat[i]) idx++;
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        tick(3);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d need=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i][8:0] !== {1'b0, eb[i]}) begin
                errors++; $display("FAIL bp_beat%0d got=%h need=%h", i, got_q[i][8:0], {1'b0, eb[i]});
            end
        end
    endtask

    task automatic test_null_last;
        got_q.delete(); got_t.delete();
        m_tready = 1'b1;
        send_word($urandom, 4'h0, 1'b1);
        tick(3);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL null_beats got=%0d need=0", got_q.size()); end
        checks++; if (err_null_last !== 1'b1) begin errors++; $display("FAIL null_err got=%b need=1", err_null_last); end
        checks++; if (pkt_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL null_pkt_cnt got=%0d need=%0d", pkt_cnt, 4'(exp_cnt)); end
        send_word(32'h1234BEEF, 4'b0011, 1'b1);
        wait_beats(2);
        tick(2);
        exp_cnt++;
        checks++;
        if (got_q.size() != 2 || got_q[0][8:0] !== 9'h0EF || got_q[1][8:0] !== 9'h1BE) begin
            errors++; $display("FAIL null_next got n=%0d first=%h second=%h, need n=2 0ef 1be",
                               got_q.size(), got_q[0][8:0], got_q[1][8:0]);
        end
        checks++; if (err_null_last !== 1'b1) begin errors++; $display("FAIL null_sticky got=%b need=1", err_null_last); end
        checks++; if (pkt_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL null_next_cnt got=%0d need=%0d", pkt_cnt, 4'(exp_cnt)); end
    endtask

    task automatic test_wrap_and_async_reset;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        exp_cnt = 0;
        got_q.delete(); got_t.delete();
        m_tready = 1'b1;
        for (int i = 0; i < 17; i++) send_word($urandom, 4'b0001, 1'b1);
        wait_beats(17);
        tick(2);
        exp_cnt = 17;
        checks++; if (pkt_cnt !== 4'(exp_cnt)) begin errors++; $display("FAIL wrap_pkt_cnt got=%0d need=%0d", pkt_cnt, 4'(exp_cnt)); end
        send_word($urandom, 4'h0, 1'b1);
        tick(1);
        m_tready = 1'b0;
        send_word(32'hD4C3B2A1, 4'hF, 1'b0);
        m_tready = 1'b1;
        tick(2);
        m_tready = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hC3 || err_null_last !== 1'b1) begin
            errors++; $display("FAIL wrap_midword got valid=%b data=%h err=%b, need 1 c3 1", m_tvalid, m_tdata, err_null_last);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || pkt_cnt !== 4'd0 || err_null_last !== 1'b0) begin
            errors++; $display("FAIL async_reset got valid=%b last=%b cnt=%0d err=%b, need 0 0 0 0",
                               m_tvalid, m_tlast, pkt_cnt, err_null_last);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_cnt = 0;
        m_tready = 1'b1;
        tick(2);
    endtask

    task automatic test_random_soak;
        int nlast = 0;
        int glast = 0;
        bit src_done = 0;
        got_q.delete(); got_t.delete(); exp_q.delete();
        fork
            begin
                logic [31:0] d;
                logic [3:0]  k;
                logic        l;
                for (int w = 0; w < 1000; w++) begin
                    while ($urandom_range(0, 2) != 0) tick(1);
                    d = $urandom;
                    k = 4'($urandom_range(0, 15));
                    l = ($urandom_range(0, 3) == 0);
                    for (int j = 0; j < 4; j++)
                        if (k[j]) exp_q.push_back({l && ((k >> (j + 1)) == 4'd0), d[8*j +: 8]});
                    if (l && k != 4'd0) nlast++;
                    send_word(d, k, l);
                end
                src_done = 1;
            end
            begin
                int t = 0;
                while ((!src_done || got_q.size() < exp_q.size()) && t < 40000) begin
                    m_tready = ($urandom_range(0, 2) == 0);
                    tick(1);
                    t++;
                end
                m_tready = 1'b1;
            end
        join
        tick(3);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL soak_count got=%0d bytes need=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i][8:0] !== exp_q[i]) begin
                errors++; $display("FAIL soak_beat%0d got=%h need=%h", i, (i < got_q.size()) ? got_q[i][8:0] : 9'h0, exp_q[i]);
            end
        end
        foreach (got_q[i]) if (got_q[i][8]) glast++;
        checks++; if (glast != nlast) begin errors++; $display("FAIL soak_tlast got=%0d need=%0d", glast, nlast); end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_sparse_null();
        test_backpressure();
        test_null_last();
        test_wrap_and_async_reset();
        test_random_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi4s_byte_downsizer.md
Name: axi4s_byte_downsizer

Overview:
- Downstream neighbour of the AXI4-Stream FIFO.
- Takes the FIFO's multi-byte words (tdata/tkeep/tlast) and serialises them into a one-byte-per-beat AXI4-Stream for byte-oriented consumers (UART, SPI, byte framers).
- Null bytes (tkeep=0) are dropped. Packet boundaries (tlast) are preserved on the last kept byte.
- Also provides a completed-packet counter and a sticky protocol-error flag.

Parameters:
- IN_BYTES, 4: input word width in bytes; legal range 2..16.
- CNTW, 16: width of the packet counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- s_tdata  input  IN_BYTES*8  input word; byte lane i = bits [8i+7:8i].
- s_tkeep  input  IN_BYTES  per-lane keep; 1 = lane carries a data byte.
- s_tlast  input  1  last word of packet.
- s_tvalid  input  1  input valid.
- s_tready  output  1  input ready.
- m_tdata  output  8  output byte.
- m_tlast  output  1  last byte of packet.
- m_tvalid  output  1  output valid.
- m_tready  input  1  output ready.
- pkt_cnt  output  CNTW  count of packets completed on the output (m_tlast handshakes); wraps modulo 2^CNTW.
- err_null_last  output  1  sticky; set when an input word with tlast=1 and tkeep=0 is accepted.

Behaviour:

Internal state:
- buf_data (IN_BYTES*8)
- rem (IN_BYTES): mask of kept lanes not yet emitted
- buf_last
- pkt_cnt
- err_null_last

Reset (async, reset_n=0):
- rem=0, buf_last=0, pkt_cnt=0, err_null_last=0.
- Hence m_tvalid=0 and m_tlast=0. s_tready=1 once reset_n is high.
- buf_data is don't-care.
- Reset mid-packet discards the buffered word without emitting it.

Output (combinational from registered state):
- m_tvalid = |rem.
- m_tdata = buf_data lane at the lowest set bit of rem. Lane order is least-significant first (lane 0 first).
- m_tlast = buf_last & (rem has exactly one bit set).
- m_tdata and m_tlast are stable while m_tvalid=1 and m_tready=0.

Input ready:
- s_tready = (rem==0) | (m_tready & rem has exactly one bit set).
- This permits back-to-back words at full byte rate with no bubble.
- s_tready does not depend on s_tvalid.

Per cycle, with out_hs = m_tvalid & m_tready and in_hs = s_tvalid & s_tready:
- in_hs: buf_data<=s_tdata, rem<=s_tkeep, buf_last<=s_tlast. This overrides the out_hs clear of the final bit.
- out_hs & ~in_hs: clear the lowest set bit of rem.
- out_hs & m_tlast: pkt_cnt<=pkt_cnt+1, wrapping.
- in_hs & s_tlast & (s_tkeep==0): err_null_last<=1. The word loads rem=0, so no byte is emitted and no packet is counted.
- in_hs & ~s_tlast & (s_tkeep==0): the word is consumed silently and s_tready stays high next cycle. Not an error.

Timing:
- Latency: first byte of an accepted word is valid the cycle after the input handshake.
- Throughput: one byte per cycle while m_tready=1.
- An input word with k kept lanes occupies the block for k output handshakes.

Sparse keep:
- Non-contiguous keep (e.g. 4'b1010) emits lanes 1 then 3. Gaps take no cycles.

Invariants:
- The block never emits a byte whose lane had tkeep=0.
- The block never drops a kept byte.

Test Plan:
- Full words, free-running sink: words 32'h44332211 and 32'h88776655, tkeep=4'hF, tlast on the second word → bytes 11,22,33,44,55,66,77,88 on consecutive cycles; m_tlast only with 88; pkt_cnt 0→1; s_tready low for 3 of every 4 cycles.
- Sparse and null keep: word 32'hDDCCBBAA keep=4'b1010 tlast=0, then word keep=4'h0 tlast=0, then 32'h000000EE keep=4'b0001 tlast=1 → output BB, DD, EE with m_tlast on EE; err_null_last stays 0.
- Backpressure: m_tready pattern 1,0,0,1,0,1,1 on word 32'h04030201 keep=4'hF → m_tdata holds 02 while stalled; bytes 01,02,03,04 emitted exactly once each; s_tready rises only in the cycle 04 is accepted.
- Null last error: word keep=4'h0 tlast=1 → no output beat; err_null_last=1 and stays set; pkt_cnt unchanged; the next word is processed normally.
- Counter wrap and reset: CNTW=4, send 17 one-byte packets (keep=4'b0001, tlast=1) → pkt_cnt=1. Then assert reset_n=0 asynchronously mid-word (rem=4'b1100) → m_tvalid=0, pkt_cnt=0 and err_null_last=0 immediately, without waiting for a clock edge.
- Random soak: Poisson-gapped source and sink (mean 2), 1000 words with random keep/last → output byte sequence equals the reference model's kept-lane sequence; m_tlast count equals the number of tlast words with nonzero keep.
